// File: rtl/trig_pkg.sv
// Shared trigger codes, code checks and stimulus FSM state type.
// Imported by the stimulus generator and the trigger detector.
package trig_pkg;

  localparam logic [2:0] EV_NONE = 3'd0;
  localparam logic [2:0] EV_RISE = 3'd1;
  localparam logic [2:0] EV_FALL = 3'd2;
  localparam logic [2:0] EV_ZERO = 3'd3;
  localparam logic [2:0] EV_ONE  = 3'd4;
  localparam logic [2:0] EV_BOTH = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } stim_state_e;

  function automatic logic is_valid_code(
    input logic [2:0] c
  );
    return (c >= EV_RISE) && (c <= EV_BOTH);
  endfunction

  function automatic logic is_level_code(
    input logic [2:0] c
  );
    return (c == EV_ZERO) || (c == EV_ONE);
  endfunction

endpackage

// File: rtl/stim_timer.sv
// Loadable phase counter: counts 0..limit, wraps to 0 after limit.
// Ports: CLOCK, RESET (async low), load (clear), en, limit, tc.
module stim_timer
  import trig_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          tc
);

  localparam logic [CW-1:0] ONE = 1;

  logic [CW-1:0] q;

  assign tc = (q == limit);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      q <= '0;
    end else if (load) begin
      q <= '0;
    end else if (en) begin
      q <= tc ? '0 : q + ONE;
    end
  end

endmodule

// File: rtl/trig_stim_gen.sv
// Trigger stimulus generator: edge/level patterns on OUT.
// Ports: CLOCK, RESET, START, trig_event, HOLD, COUNT; OUT, BUSY, EVT, DONE, ERR.
module trig_stim_gen
  import trig_pkg::*;
#(
  parameter logic IDLE_LVL = 1'b0,
  parameter int   CW       = 8
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          START,
  input  logic [2:0]    trig_event,
  input  logic [CW-1:0] HOLD,
  input  logic [CW-1:0] COUNT,
  output logic          OUT,
  output logic          BUSY,
  output logic          EVT,
  output logic          DONE,
  output logic          ERR
);

  localparam logic [CW-1:0] ONE = 1;

  stim_state_e   state, state_n;
  logic [2:0]    code_q, code_n;
  logic [CW-1:0] hold_q, hold_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [CW-1:0] ev_q, ev_n;
  logic          half_q, half_n;
  logic          out_q, out_n;
  logic          busy_q, busy_n;
  logic          evt_q, evt_n;
  logic          done_q, done_n;
  logic          err_q, err_n;

  logic          tc;
  logic          lvl;
  logic          last;
  logic [CW-1:0] limit;

  assign lvl   = is_level_code(code_q);
  // Level modes advance one event per cycle.
  assign limit = lvl ? '0 : hold_q;

  stim_timer #(.CW(CW)) u_timer (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .load  (state != ST_RUN),
    .en    (state == ST_RUN),
    .limit (limit),
    .tc    (tc)
  );

  // Edge modes end after the second half of the final event.
  always_comb begin
    last = 1'b0;
    if (lvl) begin
      last = (ev_q == cnt_q);
    end else if (code_q == EV_BOTH) begin
      last = tc && (ev_q == cnt_q);
    end else begin
      last = tc && half_q && (ev_q == cnt_q);
    end
  end

  always_comb begin
    state_n = state;
    code_n  = code_q;
    hold_n  = hold_q;
    cnt_n   = cnt_q;
    ev_n    = ev_q;
    half_n  = half_q;
    out_n   = out_q;
    busy_n  = busy_q;
    evt_n   = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        out_n  = IDLE_LVL;
        busy_n = 1'b0;
        if (START) begin
          if (!is_valid_code(trig_event)) begin
            err_n = 1'b1;
          end else if (COUNT == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = ST_RUN;
            code_n  = trig_event;
            hold_n  = HOLD;
            cnt_n   = COUNT;
            ev_n    = ONE;
            half_n  = 1'b0;
            busy_n  = 1'b1;
            unique case (1'b1)
              (trig_event == EV_RISE): out_n = 1'b0;
              (trig_event == EV_FALL): out_n = 1'b1;
              (trig_event == EV_ZERO): begin
                out_n = 1'b0;
                evt_n = 1'b1;
              end
              (trig_event == EV_ONE): begin
                out_n = 1'b1;
                evt_n = 1'b1;
              end
              default: begin
                out_n = ~IDLE_LVL;
                evt_n = 1'b1;
              end
            endcase
          end
        end
      end
      ST_RUN: begin
        busy_n = 1'b1;
        if (last) begin
          state_n = ST_FIN;
          out_n   = IDLE_LVL;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else if (lvl) begin
          ev_n  = ev_q + ONE;
          evt_n = 1'b1;
        end else if (tc) begin
          out_n = ~out_q;
          if (code_q == EV_BOTH) begin
            ev_n  = ev_q + ONE;
            evt_n = 1'b1;
          end else if (!half_q) begin
            half_n = 1'b1;
            evt_n  = 1'b1;
          end else begin
            half_n = 1'b0;
            ev_n   = ev_q + ONE;
          end
        end
      end
      ST_FIN: begin
        state_n = ST_IDLE;
        out_n   = IDLE_LVL;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
        out_n   = IDLE_LVL;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state  <= ST_IDLE;
      code_q <= EV_NONE;
      hold_q <= '0;
      cnt_q  <= '0;
      ev_q   <= '0;
      half_q <= 1'b0;
      out_q  <= IDLE_LVL;
      busy_q <= 1'b0;
      evt_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      code_q <= code_n;
      hold_q <= hold_n;
      cnt_q  <= cnt_n;
      ev_q   <= ev_n;
      half_q <= half_n;
      out_q  <= out_n;
      busy_q <= busy_n;
      evt_q  <= evt_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  assign OUT  = out_q;
  assign BUSY = busy_q;
  assign EVT  = evt_q;
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule
